// File: rtl/cim_pkg.sv
// Shared types, default sizing and the per-element saturating adder for the
// CIM accumulation block.
package cim_pkg;

   localparam int CIM_NUM_CH = 2;
   localparam int CIM_TILE   = 6;
   localparam int CIM_IN_W   = 12;
   localparam int CIM_ACC_W  = 14;
   localparam int CIM_ADDR_W = 8;

   typedef enum logic [1:0] {
      SCAN_NOP = 2'b00,
      SCAN_WR  = 2'b01,
      SCAN_RD  = 2'b10,
      SCAN_CLR = 2'b11
   } scan_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   // Signed add of an accumulator element and a sign-extended tile element,
   // clamped to the acc_w-bit signed range. Operands arrive sign-extended to
   // 32 bits; the caller truncates the result back to acc_w.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                  input logic signed [31:0] inc,
                                                  input int                 acc_w);
      logic signed [32:0] sum;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      sum = 33'(acc) + 33'(inc);
      hi  = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
      lo  = -(33'sd1 <<< (acc_w - 1));
      if (sum > hi)      sum = hi;
      else if (sum < lo) sum = lo;
      return sum[31:0];
   endfunction

endpackage

// File: rtl/cim_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// priority pointer; the pointer moves past the winner on every grant.
module cim_rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   localparam int            PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW:0]   NV = (PW+1)'(N);
   localparam logic [PW-1:0] NM1 = PW'(N - 1);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;
   logic          found;

   // Scan requesters starting at the pointer, wrapping modulo N
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (sum >= NV) sum = sum - NV;
         idx = sum[PW-1:0];
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_d      = (idx == NM1) ? '0 : idx + PW'(1);
         end
      end
   end

   // Priority pointer, back to channel 0 on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/cim_accum_top.sv
// Multi-channel CIM accumulation buffer: RR-arbitrated PE packets run through
// a read-add-write pipeline (S0 capture, S1 line read, S2 saturate+write) with
// S2->S1 forwarding; a scan port writes, reads and bulk-clears the buffer.
module cim_accum_top
   import cim_pkg::*;
#(
   parameter int NUM_CH = CIM_NUM_CH,
   parameter int TILE   = CIM_TILE,
   parameter int IN_W   = CIM_IN_W,
   parameter int ACC_W  = CIM_ACC_W,
   parameter int ADDR_W = CIM_ADDR_W,
   parameter int LINE_W = TILE*TILE*ACC_W
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_CH-1:0]                         pe_valid_i,
   output logic [NUM_CH-1:0]                         pe_ready_o,
   input  logic [NUM_CH-1:0][TILE*TILE-1:0][IN_W-1:0] pe_tile_i,
   input  logic [NUM_CH-1:0][ADDR_W-1:0]             pe_addr_i,
   input  logic [NUM_CH-1:0]                         pe_first_i,
   input  logic                                      scan_valid_i,
   output logic                                      scan_ready_o,
   input  logic [1:0]                                scan_mode_i,
   input  logic [ADDR_W-1:0]                         scan_addr_i,
   input  logic [LINE_W-1:0]                         scan_data_i,
   output logic [LINE_W-1:0]                         scan_data_o,
   output logic                                      scan_rvalid_o,
   output logic                                      busy_o
);

   localparam int ELEMS = TILE*TILE;
   localparam int DEPTH = 2**ADDR_W;

   typedef logic [ELEMS-1:0][IN_W-1:0]  tile_t;
   typedef logic [ELEMS-1:0][ACC_W-1:0] line_t;

   state_t            state_q, state_d;
   logic [1:0]        vld_pipe_q;          // [0]: S0 holds a packet, [1]: S1 holds a line
   logic [ADDR_W-1:0] clr_cnt_q;

   tile_t             s0_tile_q, s1_tile_q, g_tile;
   logic [ADDR_W-1:0] s0_addr_q, s1_addr_q, g_addr;
   logic              s0_first_q, s1_first_q, g_first;
   line_t             s1_line_q, rd_line, wr_line;
   line_t             mem_q [DEPTH];

   scan_mode_t        scan_mode;
   logic              scan_acc, pe_open, pe_acc, fwd_hit;

   assign scan_mode    = scan_mode_t'(scan_mode_i);
   assign busy_o       = (|vld_pipe_q) | (state_q == ST_CLEAR);
   assign scan_ready_o = scan_valid_i & ~busy_o;
   assign scan_acc     = scan_valid_i & scan_ready_o;
   // A pending non-NOP scan command starves PE traffic so the pipe drains
   assign pe_open      = (state_q != ST_CLEAR) & ~(scan_valid_i & (scan_mode != SCAN_NOP));
   assign pe_acc       = |pe_ready_o;

   cim_rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (pe_valid_i & {NUM_CH{pe_open}}),
      .gnt_o (pe_ready_o)
   );

   // Select the granted channel's packet
   always_comb begin
      g_tile  = '0;
      g_addr  = '0;
      g_first = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (pe_ready_o[c]) begin
            g_tile  = pe_tile_i[c];
            g_addr  = pe_addr_i[c];
            g_first = pe_first_i[c];
         end
      end
   end

   // The line being written this cycle is newer than the buffer copy
   assign fwd_hit = vld_pipe_q[1] & (s1_addr_q == s0_addr_q);
   assign rd_line = fwd_hit ? wr_line : mem_q[s0_addr_q];

   for (genvar e = 0; e < ELEMS; e++) begin : g_elem
      logic [ACC_W-1:0] ext, sum;
      assign ext        = ACC_W'($signed(s1_tile_q[e]));
      assign sum        = ACC_W'(sat_add(32'($signed(s1_line_q[e])),
                                         32'($signed(s1_tile_q[e])), ACC_W));
      assign wr_line[e] = s1_first_q ? ext : sum;
   end

   // FSM: clear only starts from an empty pipe, RUN tracks in-flight packets
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (scan_acc && scan_mode == SCAN_CLR) state_d = ST_CLEAR;
                   else if (pe_acc)                      state_d = ST_RUN;
         ST_RUN:   if (!pe_acc && !vld_pipe_q[0])        state_d = ST_IDLE;
         ST_CLEAR: if (clr_cnt_q == '1)                  state_d = ST_IDLE;
         default:                                        state_d = ST_IDLE;
      endcase
   end

   // Control state, clear sweep counter and the registered scan read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         vld_pipe_q    <= '0;
         clr_cnt_q     <= '0;
         scan_data_o   <= '0;
         scan_rvalid_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         vld_pipe_q    <= {vld_pipe_q[0], pe_acc};
         if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
         scan_rvalid_o <= scan_acc & (scan_mode == SCAN_RD);
         if (scan_acc && scan_mode == SCAN_RD) scan_data_o <= mem_q[scan_addr_i];
      end
   end

   // Pipeline payload: S0 takes the granted packet, S1 the (forwarded) line
   always_ff @(posedge clk) begin
      if (pe_acc) begin
         s0_tile_q  <= g_tile;
         s0_addr_q  <= g_addr;
         s0_first_q <= g_first;
      end
      if (vld_pipe_q[0]) begin
         s1_tile_q  <= s0_tile_q;
         s1_addr_q  <= s0_addr_q;
         s1_first_q <= s0_first_q;
         s1_line_q  <= rd_line;
      end
   end

   // Single buffer write port; clear, scan write and writeback never overlap
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR)                      mem_q[clr_cnt_q]   <= '0;
      else if (scan_acc && scan_mode == SCAN_WR)    mem_q[scan_addr_i] <= scan_data_i;
      else if (vld_pipe_q[1])                       mem_q[s1_addr_q]   <= wr_line;
   end

endmodule

// File: tb/tb_cim_accum_top.sv
// Directed bench for cim_accum_top: clear, forwarding, saturation, scan vs PE
// ordering and reset during a clear, all against hand-computed values.
module tb_cim_accum_top;

   localparam int NUM_CH = 2;
   localparam int TILE   = 6;
   localparam int IN_W   = 12;
   localparam int ACC_W  = 14;
   localparam int ADDR_W = 8;
   localparam int ELEMS  = TILE*TILE;
   localparam int LINE_W = ELEMS*ACC_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NUM_CH-1:0]                     pe_valid, pe_ready, pe_first;
   logic [NUM_CH-1:0][ELEMS-1:0][IN_W-1:0] pe_tile;
   logic [NUM_CH-1:0][ADDR_W-1:0]         pe_addr;
   logic                                  scan_valid, scan_ready, scan_rvalid, busy;
   logic [1:0]                            scan_mode;
   logic [ADDR_W-1:0]                     scan_addr;
   logic [LINE_W-1:0]                     scan_wdata, scan_rdata, dummy;
   int errors = 0;
   int checks = 0;
   int cnt;
   int n;

   always #5 clk = ~clk;

   cim_accum_top #(.NUM_CH(NUM_CH), .TILE(TILE), .IN_W(IN_W), .ACC_W(ACC_W),
                   .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .pe_valid_i(pe_valid), .pe_ready_o(pe_ready), .pe_tile_i(pe_tile),
      .pe_addr_i(pe_addr), .pe_first_i(pe_first),
      .scan_valid_i(scan_valid), .scan_ready_o(scan_ready), .scan_mode_i(scan_mode),
      .scan_addr_i(scan_addr), .scan_data_i(scan_wdata), .scan_data_o(scan_rdata),
      .scan_rvalid_o(scan_rvalid), .busy_o(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   function automatic logic [LINE_W-1:0] fill_line(input int v);
      logic [LINE_W-1:0] l;
      for (int e = 0; e < ELEMS; e++) l[e*ACC_W +: ACC_W] = ACC_W'(v);
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] pat_line();
      logic [LINE_W-1:0] l;
      for (int e = 0; e < ELEMS; e++) l[e*ACC_W +: ACC_W] = ACC_W'(e*100 - 1500);
      return l;
   endfunction

   task automatic scan_cmd(input logic [1:0] mode, input int addr,
                           input logic [LINE_W-1:0] data, output logic [LINE_W-1:0] rd);
      int k;
      scan_valid = 1'b1; scan_mode = mode; scan_addr = ADDR_W'(addr); scan_wdata = data;
      #1; k = 0;
      while (!scan_ready && k < 20) begin @(posedge clk); #1; k++; end
      if (k >= 20) chk("scan_timeout", 32'(k), 32'd0);
      @(posedge clk); #1;
      scan_valid = 1'b0; scan_mode = 2'b00;
      rd = scan_rdata;
      if (mode == 2'b10) chk("rvalid_pulse", 32'(scan_rvalid), 32'd1);
   endtask

   task automatic rd_chk(input string tag, input int addr, input logic [LINE_W-1:0] exp);
      logic [LINE_W-1:0] got;
      scan_cmd(2'b10, addr, '0, got);
      for (int e = 0; e < ELEMS; e++)
         chk(tag, 32'($signed(got[e*ACC_W +: ACC_W])), 32'($signed(exp[e*ACC_W +: ACC_W])));
   endtask

   task automatic do_clear(output int c);
      scan_cmd(2'b11, 0, '0, dummy);
      c = 0;
      while (busy && c < 1000) begin c++; @(posedge clk); #1; end
   endtask

   task automatic pe_send(input int ch, input int addr, input int val, input bit first);
      int k;
      pe_valid[ch] = 1'b1; pe_addr[ch] = ADDR_W'(addr); pe_first[ch] = first;
      for (int e = 0; e < ELEMS; e++) pe_tile[ch][e] = IN_W'(val);
      #1; k = 0;
      while (!pe_ready[ch] && k < 20) begin @(posedge clk); #1; k++; end
      if (k >= 20) chk("pe_timeout", 32'(k), 32'd0);
      @(posedge clk); #1;
      pe_valid[ch] = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t exceeded limit 1000000", $time);
      $fatal(1);
   end

   initial begin
      pe_valid = '0; pe_first = '0; pe_tile = '0; pe_addr = '0;
      scan_valid = 1'b0; scan_mode = 2'b00; scan_addr = '0; scan_wdata = '0;

      // reset values
      repeat (3) @(posedge clk); #1;
      chk("rst_pe_ready", 32'(pe_ready), 32'd0);
      chk("rst_scan_ready", 32'(scan_ready), 32'd0);
      chk("rst_sdata_nz", 32'(|scan_rdata), 32'd0);
      chk("rst_rvalid", 32'(scan_rvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_clear(cnt);
      chk("clr_cycles", 32'(cnt), 32'd256);

      // two channels hammer the same line back to back
      pe_valid = 2'b11; pe_first = 2'b00; pe_addr[0] = 8'd7; pe_addr[1] = 8'd7;
      for (int e = 0; e < ELEMS; e++) begin pe_tile[0][e] = 12'd100; pe_tile[1][e] = 12'd100; end
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fwd_gnt", 32'(pe_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
         @(posedge clk); #1;
      end
      pe_valid = 2'b00;
      rd_chk("fwd_sum", 7, fill_line(400));
      @(posedge clk); #1;
      chk("rvalid_drop", 32'(scan_rvalid), 32'd0);
      scan_cmd(2'b00, 7, fill_line(1), dummy);
      rd_chk("nop_keep", 7, fill_line(400));

      // clear then overwrite/accumulate
      do_clear(cnt);
      chk("clr_cycles2", 32'(cnt), 32'd256);
      pe_send(0, 5, 3, 1'b1);
      pe_send(0, 5, -1, 1'b0);
      rd_chk("acc_sum", 5, fill_line(2));
      pe_send(0, 5, -5, 1'b1);
      rd_chk("first_ovw", 5, fill_line(-5));

      // saturation at both rails
      pe_send(0, 20, 2047, 1'b1);
      repeat (4) pe_send(0, 20, 2047, 1'b0);
      pe_send(0, 21, -2048, 1'b1);
      repeat (4) pe_send(0, 21, -2048, 1'b0);
      rd_chk("sat_pos", 20, fill_line(8191));
      rd_chk("sat_neg", 21, fill_line(-8192));
      pe_send(0, 20, -1, 1'b0);
      rd_chk("sat_nowrap", 20, fill_line(8190));

      // scan write requested with packets in flight
      pe_send(1, 30, 1, 1'b1);
      pe_send(1, 30, 1, 1'b0);
      pe_send(1, 30, 1, 1'b0);
      pe_valid[0] = 1'b1; pe_addr[0] = 8'd40; pe_first[0] = 1'b1;
      for (int e = 0; e < ELEMS; e++) pe_tile[0][e] = 12'd5;
      scan_valid = 1'b1; scan_mode = 2'b01; scan_addr = 8'd9; scan_wdata = pat_line();
      #1; n = 0;
      while (!scan_ready && n < 10) begin
         chk("sp_pe_blk", 32'(pe_ready), 32'd0);
         chk("sp_busy_hi", 32'(busy), 32'd1);
         @(posedge clk); #1; n++;
      end
      chk("sp_busy_lo", 32'(busy), 32'd0);
      chk("sp_pe_blk2", 32'(pe_ready), 32'd0);
      chk("sp_lat_le3", 32'(n <= 3), 32'd1);
      @(posedge clk); #1;
      scan_valid = 1'b0; scan_mode = 2'b00;
      #1;
      chk("sp_pe_resume", 32'(pe_ready), 32'd1);
      @(posedge clk); #1;
      pe_valid = 2'b00;
      rd_chk("sp_wr9", 9, pat_line());
      rd_chk("sp_pe30", 30, fill_line(3));
      rd_chk("sp_pe40", 40, fill_line(5));

      // reset in the middle of a clear
      scan_cmd(2'b11, 0, '0, dummy);
      repeat (50) @(posedge clk);
      #1;
      pe_valid = 2'b11; scan_valid = 1'b1; scan_mode = 2'b10;
      #1;
      chk("clr_pe_blk", 32'(pe_ready), 32'd0);
      chk("clr_scan_blk", 32'(scan_ready), 32'd0);
      chk("clr_busy", 32'(busy), 32'd1);
      pe_valid = 2'b00; scan_valid = 1'b0; scan_mode = 2'b00;
      repeat (50) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pe_ready", 32'(pe_ready), 32'd0);
      chk("mid_rst_scan_ready", 32'(scan_ready), 32'd0);
      chk("mid_rst_sdata_nz", 32'(|scan_rdata), 32'd0);
      chk("mid_rst_rvalid", 32'(scan_rvalid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      scan_cmd(2'b01, 9, pat_line(), dummy);
      scan_cmd(2'b01, 255, pat_line(), dummy);
      do_clear(cnt);
      chk("clr_after_rst", 32'(cnt), 32'd256);
      rd_chk("clr_line9", 9, fill_line(0));
      rd_chk("clr_line255", 255, fill_line(0));
      pe_valid = 2'b11;
      #1;
      chk("ptr_after_rst", 32'(pe_ready), 32'd1);
      pe_valid = 2'b00;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
